// File: rtl/ctrl_pkg.sv
// Shared transceiver control types: frame size, WS format, slot length helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f24bits = 2'd1,
    f32bits = 2'd2
  } frame_size_t;

  typedef enum logic {
    WS_I2S = 1'b0,
    WS_LJ  = 1'b1
  } ws_mode_t;

  // Smallest usable pclk-per-sck ratio; lower div values are promoted to it.
  localparam int DIV_MIN = 2;

  // Slot length in bits for a frame size code (unused code falls back to 16).
  function automatic logic [5:0] slot_len(input frame_size_t fs);
    case (fs)
      f24bits: return 6'd24;
      f32bits: return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/i2s_clk_gen_if.sv
// Configuration and clock/position bundle of the I2S/TDM clock generator.
// I2S_TDM_EN adds the num_ch slot-count field.
interface i2s_clk_gen_if #(
  parameter int DIV_W  = 8,
  parameter int MAX_CH = 8
);
  import ctrl_pkg::*;

  localparam int CH_W = $clog2(MAX_CH);

  logic             en;
  logic [DIV_W-1:0] div;
  frame_size_t      frame_size;
  ws_mode_t         ws_mode;
`ifdef I2S_TDM_EN
  logic [CH_W:0]    num_ch;
`endif
  logic             sck;
  logic             sck_rise;
  logic             sck_fall;
  logic             ws;
  logic             frame_start;
  logic [CH_W-1:0]  slot;
  logic [4:0]       bit_idx;

  // Generator side: takes configuration, drives clocks and position.
  modport master (
    input  en, div, frame_size, ws_mode,
`ifdef I2S_TDM_EN
    input  num_ch,
`endif
    output sck, sck_rise, sck_fall, ws, frame_start, slot, bit_idx
  );

  // Consumer side: serializer/deserializer and register block.
  modport slave (
    output en, div, frame_size, ws_mode,
`ifdef I2S_TDM_EN
    output num_ch,
`endif
    input  sck, sck_rise, sck_fall, ws, frame_start, slot, bit_idx
  );

endinterface

// File: rtl/i2s_clk_gen_sck_div.sv
// Integer pclk divider producing sck plus registered rise/fall strobes.
// d must already be clamped to >= 2 by the caller.
module sck_div #(
  parameter int DIV_W = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] d,
  output logic             sck,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic             fall_now
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_m1;
  logic [DIV_W-1:0] half_m1;
  logic [DIV_W:0]   half;
  logic             rise_now;

  // Low phase is ceil(d/2); fall fires at the last count (>= guards a shrunk d).
  always_comb begin
    d_m1     = d - 1'b1;
    half     = ({1'b0, d} + 1'b1) >> 1;
    half_m1  = DIV_W'(half - 1'b1);
    fall_now = en && (cnt >= d_m1);
    rise_now = en && !fall_now && (cnt == half_m1);
  end

  // Count, sck level and strobes all register on the same edge (no skew).
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt      <= '0;
      sck      <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
    end else begin
      sck_rise <= rise_now;
      sck_fall <= fall_now;
      if (fall_now) begin
        cnt <= '0;
        sck <= 1'b0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
        if (rise_now) sck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S/TDM master clock generator: shadowed config, bit/slot position, ws.
// I2S_TDM_EN: honour num_ch and drive ws as a one-sck frame-sync pulse;
// otherwise two slots and stereo ws.
module i2s_clk_gen
  import ctrl_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int MAX_CH = 8
) (
  input logic           pclk,
  input logic           rst,
  i2s_clk_gen_if.master bus
);

  localparam int CH_W = $clog2(MAX_CH);

  logic [DIV_W-1:0] sh_div;
  frame_size_t      sh_fs;
  ws_mode_t         sh_mode;
  logic [CH_W-1:0]  sh_last;

  logic [CH_W-1:0]  in_last;
  logic [DIV_W-1:0] d_eff;
  logic             fall_now;
  logic             frame_wrap;
  frame_size_t      eff_fs;
  ws_mode_t         eff_mode;
  logic [CH_W-1:0]  eff_last;

  logic [4:0]       bit_q;
  logic [CH_W-1:0]  slot_q;
  logic             ws_q;
  logic             fs_q;
  logic [4:0]       len_m1;
  logic [4:0]       nbit;
  logic [CH_W-1:0]  nslot;
  logic             ws_n;
`ifndef I2S_TDM_EN
  logic [CH_W-1:0]  fslot;
`endif

  // Last slot index of the incoming configuration (count clamped to 2..MAX_CH).
`ifdef I2S_TDM_EN
  logic [CH_W:0] nch_c;
  always_comb begin
    if (bus.num_ch < (CH_W+1)'(2))           nch_c = (CH_W+1)'(2);
    else if (bus.num_ch > (CH_W+1)'(MAX_CH)) nch_c = (CH_W+1)'(MAX_CH);
    else                                     nch_c = bus.num_ch;
    in_last = CH_W'(nch_c - 1'b1);
  end
`else
  always_comb in_last = CH_W'(1);
`endif

  // Divide ratios below DIV_MIN run as DIV_MIN.
  always_comb d_eff = (sh_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : sh_div;

  sck_div #(.DIV_W(DIV_W)) u_sck_div (
    .pclk     (pclk),
    .rst      (rst),
    .en       (bus.en),
    .d        (d_eff),
    .sck      (bus.sck),
    .sck_rise (bus.sck_rise),
    .sck_fall (bus.sck_fall),
    .fall_now (fall_now)
  );

  // At the frame-start edge the incoming config already governs the new frame.
  always_comb begin
    frame_wrap = fall_now && (bit_q == 5'd0) && (slot_q >= sh_last);
    eff_fs     = frame_wrap ? bus.frame_size : sh_fs;
    eff_mode   = frame_wrap ? bus.ws_mode    : sh_mode;
    eff_last   = frame_wrap ? in_last        : sh_last;
  end

  // Position and ws that the next sck_fall will load.
  always_comb begin
    len_m1 = 5'(slot_len(eff_fs) - 6'd1);
    if (bit_q == 5'd0) begin
      nbit  = len_m1;
      nslot = (slot_q >= sh_last) ? '0 : slot_q + 1'b1;
    end else begin
      nbit  = bit_q - 5'd1;
      nslot = slot_q;
    end
`ifdef I2S_TDM_EN
    if (eff_mode == WS_LJ) ws_n = (nslot == '0) && (nbit == len_m1);
    else                   ws_n = (nslot == eff_last) && (nbit == 5'd0);
`else
    // I2S announces the slot of the following bit, one sck ahead of its MSB.
    if (nbit == 5'd0) fslot = (nslot >= eff_last) ? '0 : nslot + 1'b1;
    else              fslot = nslot;
    ws_n = (eff_mode == WS_LJ) ? nslot[0] : fslot[0];
`endif
  end

  // Shadow config: track inputs while idle or in reset, latch at frame start.
  always_ff @(posedge pclk) begin
    if (rst || !bus.en || frame_wrap) begin
      sh_div  <= bus.div;
      sh_fs   <= bus.frame_size;
      sh_mode <= bus.ws_mode;
      sh_last <= in_last;
    end
  end

  // Position counters and ws advance on sck_fall; reset parks on the last slot.
  always_ff @(posedge pclk) begin
    if (rst) begin
      bit_q  <= 5'd0;
      slot_q <= in_last;
      ws_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      fs_q <= frame_wrap;
      if (fall_now) begin
        bit_q  <= nbit;
        slot_q <= nslot;
        ws_q   <= ws_n;
      end
    end
  end

  assign bus.bit_idx     = bit_q;
  assign bus.slot        = slot_q;
  assign bus.ws          = ws_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Scoreboard bench for i2s_clk_gen: an arithmetic model of position vs. cycle
// pushes the expected output word each cycle; the sampled DUT word is popped
// against it on the falling pclk edge.
module tb_i2s_clk_gen;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       sck;
    logic       rise;
    logic       fall;
    logic       ws;
    logic       fs;
    logic [2:0] slot;
    logic [4:0] bit_idx;
  } obs_t;

`ifdef I2S_TDM_EN
  localparam bit TDM = 1'b1;
`else
  localparam bit TDM = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  always #5 pclk = ~pclk;

  i2s_clk_gen_if #(.DIV_W(8), .MAX_CH(8)) bus ();

  i2s_clk_gen #(.DIV_W(8), .MAX_CH(8)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Expected outputs m edges into a segment at divider count 0 with kbase
  // sck falls already done; m=0 means the cycle right after reset.
  function automatic obs_t model(int m, int d, int kbase, int len, int nch, bit lj, bit tdm);
    obs_t e;
    int ph, h, k, b, fl, s, s2;
    e  = '0;
    h  = (d + 1) / 2;
    fl = len * nch;
    if (m > 0) begin
      ph     = (m - 1) % d;
      e.sck  = (ph >= h - 1) && (ph < d - 1);
      e.rise = (ph == h - 1);
      e.fall = (ph == d - 1);
    end
    k = kbase + m / d;
    if (k == 0) begin
      e.slot = 3'(nch - 1);
    end else begin
      b         = k - 1;
      s         = (b / len) % nch;
      s2        = ((b + 1) / len) % nch;
      e.slot    = 3'(s);
      e.bit_idx = 5'(len - 1 - (b % len));
      e.fs      = e.fall && (b % fl == 0);
      if (tdm) e.ws = lj ? (b % fl == 0) : (b % fl == fl - 1);
      else     e.ws = lj ? s[0] : s2[0];
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.sck     = bus.sck;
    o.rise    = bus.sck_rise;
    o.fall    = bus.sck_fall;
    o.ws      = bus.ws;
    o.fs      = bus.frame_start;
    o.slot    = bus.slot;
    o.bit_idx = bus.bit_idx;
    return o;
  endfunction

  // One reset edge with the given configuration applied, released afterwards.
  task automatic start(int d, frame_size_t fsz, ws_mode_t md, int nch);
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.div        = 8'(d);
    bus.frame_size = fsz;
    bus.ws_mode    = md;
`ifdef I2S_TDM_EN
    bus.num_ch     = 4'(nch);
`else
    if (nch != 2) $display("note: stereo build ignores nch=%0d", nch);
`endif
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    start(4, f16bits, WS_LJ, 2);
    sb.push_back(model(0, 4, 0, 16, 2, 1'b1, TDM));
    e = sb.pop_front();
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", o, e);
    end
  endtask

  task automatic test_lj_d4();
    obs_t e, o;
    start(4, f16bits, WS_LJ, 2);
    for (int n = 1; n <= 300; n++) begin
      sb.push_back(model(n, 4, 0, 16, 2, 1'b1, TDM));
      @(posedge pclk);
      @(negedge pclk);
      o = sample();
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lj_d4 n=%0d got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_i2s_d5();
    obs_t e, o;
    start(5, f24bits, WS_I2S, 2);
    for (int n = 1; n <= 520; n++) begin
      sb.push_back(model(n, 5, 0, 24, 2, 1'b0, TDM));
      @(posedge pclk);
      @(negedge pclk);
      o = sample();
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL i2s_d5 n=%0d got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_div_small();
    obs_t e, o;
    for (int v = 1; v >= 0; v--) begin
      start(v, f16bits, WS_LJ, 2);
      for (int n = 1; n <= 40; n++) begin
        sb.push_back(model(n, 2, 0, 16, 2, 1'b1, TDM));
        @(posedge pclk);
        @(negedge pclk);
        o = sample();
        e = sb.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL div_small div=%0d n=%0d got %h expected %h", v, n, o, e);
        end
      end
    end
  endtask

  // div moves 4 -> 6 mid-frame; new ratio starts at the frame-1 boundary (edge 132).
  task automatic test_div_change();
    obs_t e, o;
    start(4, f16bits, WS_LJ, 2);
    for (int n = 1; n <= 260; n++) begin
      if (n <= 132) sb.push_back(model(n, 4, 0, 16, 2, 1'b1, TDM));
      else          sb.push_back(model(n - 132, 6, 33, 16, 2, 1'b1, TDM));
      @(posedge pclk);
      @(negedge pclk);
      o = sample();
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL div_change n=%0d got %h expected %h", n, o, e);
      end
      if (n == 50) bus.div = 8'd6;
    end
  endtask

  task automatic test_en_freeze();
    obs_t e, o;
    int   m;
    m = 0;
    start(4, f16bits, WS_LJ, 2);
    for (int n = 1; n <= 90; n++) begin
      if (n == 31) bus.en = 1'b0;
      if (n == 41) bus.en = 1'b1;
      if (bus.en) begin
        m++;
        sb.push_back(model(m, 4, 0, 16, 2, 1'b1, TDM));
      end else begin
        e      = model(m, 4, 0, 16, 2, 1'b1, TDM);
        e.rise = 1'b0;
        e.fall = 1'b0;
        e.fs   = 1'b0;
        sb.push_back(e);
      end
      @(posedge pclk);
      @(negedge pclk);
      o = sample();
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_freeze n=%0d got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_rst_mid();
    obs_t e, o;
    start(4, f16bits, WS_I2S, 2);
    for (int n = 1; n <= 100; n++) begin
      if (n == 71) rst = 1'b1;
      if (n == 72) rst = 1'b0;
      if (n <= 70)      sb.push_back(model(n, 4, 0, 16, 2, 1'b0, TDM));
      else              sb.push_back(model(n - 71, 4, 0, 16, 2, 1'b0, TDM));
      @(posedge pclk);
      @(negedge pclk);
      o = sample();
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_mid n=%0d got %h expected %h", n, o, e);
      end
    end
  endtask

`ifdef I2S_TDM_EN
  task automatic test_tdm();
    obs_t e, o;
    for (int lj = 1; lj >= 0; lj--) begin
      start(2, f32bits, lj ? WS_LJ : WS_I2S, 4);
      for (int n = 1; n <= 600; n++) begin
        sb.push_back(model(n, 2, 0, 32, 4, 1'(lj), 1'b1));
        @(posedge pclk);
        @(negedge pclk);
        o = sample();
        e = sb.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL tdm lj=%0d n=%0d got %h expected %h", lj, n, o, e);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.en         = 1'b1;
    bus.div        = 8'd4;
    bus.frame_size = f16bits;
    bus.ws_mode    = WS_LJ;
`ifdef I2S_TDM_EN
    bus.num_ch     = 4'd2;
`endif
    test_reset();
    test_lj_d4();
    test_i2s_d5();
    test_div_small();
    test_div_change();
    test_en_freeze();
    test_rst_mid();
`ifdef I2S_TDM_EN
    test_tdm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
